note_sequencer: RTL

Record/playback controller that sits between the keypad encoder and the frequency divider and decides which note code drives the tone datapath. It passes live keypad notes through, records a sequence of note codes into a small buffer, and loops the recorded sequence at a fixed step rate. Live key presses override playback without disturbing the playback position.

---
 rtl/note_sequencer_if.sv | 45 ++++
 rtl/note_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer_if.sv
// -----------------------------------------------------------------------------
// note_sequencer_if
//
// Purpose:
//   Groups the keypad-side inputs and the tone-datapath-side outputs of the
//   note sequencer into one bundle. The master modport is the side that drives
//   the keypad strobes and codes (encoder / bench). The slave modport is the
//   sequencer itself.
//
// Signals:
//   keycode_i  [3:0]   live note code from the encoder, 0 = no key
//   key_edge           one-cycle strobe, new key press
//   rec_edge           one-cycle strobe, toggle recording
//   play_edge          one-cycle strobe, toggle playback
//   keycode_o  [3:0]   note code to the frequency divider (registered)
//   note_en            keycode_o is a sounding note (registered)
//   state_o    [1:0]   IDLE=0, RECORD=1, PLAY=2
//   step_o     [AW-1:0] current playback index (registered)
//
// DEPTH must match the DEPTH of the note_sequencer bound to this interface.
// -----------------------------------------------------------------------------
interface note_sequencer_if #(
  parameter int DEPTH = 16
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [3:0]    keycode_i;
  logic          key_edge;
  logic          rec_edge;
  logic          play_edge;
  logic [3:0]    keycode_o;
  logic          note_en;
  logic [1:0]    state_o;
  logic [AW-1:0] step_o;

  modport master (
    output keycode_i, key_edge, rec_edge, play_edge,
    input  keycode_o, note_en, state_o, step_o
  );

  modport slave (
    input  keycode_i, key_edge, rec_edge, play_edge,
    output keycode_o, note_en, state_o, step_o
  );
endinterface

// File: rtl/note_sequencer.sv
// -----------------------------------------------------------------------------
// note_sequencer
//
// Purpose:
//   Record/playback controller between the keypad encoder and the frequency
//   divider. Passes live notes through, records a sequence of nonzero note
//   codes into a DEPTH-entry buffer, and loops the recorded sequence at one
//   step per STEP_CYCLES clocks. A held live key overrides playback output
//   while the playback position keeps advancing underneath.
//
// Ports:
//   clk    system clock
//   n_rst  asynchronous active-low reset
//   bus    note_sequencer_if.slave (keypad inputs, note/state outputs)
//
// Parameters:
//   DEPTH        buffer entries, power of two, >= 2
//   STEP_CYCLES  clocks per playback step, >= 2
// -----------------------------------------------------------------------------
module note_sequencer #(
  parameter int DEPTH       = 16,
  parameter int STEP_CYCLES = 3000000
) (
  input  logic              clk,
  input  logic              n_rst,
  note_sequencer_if.slave   bus
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW   = AW + 1;
  localparam int TW   = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  localparam logic [LW-1:0] LEN_FULL   = LW'(DEPTH);
  localparam logic [TW-1:0] TIMER_LAST = TW'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RECORD = 2'd1,
    S_PLAY   = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State, pointers, counters and registered outputs
  // ---------------------------------------------------------------------------
  state_t          state_q,   state_d;
  logic [AW-1:0]   wr_ptr_q,  wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q,  rd_ptr_d;
  logic [LW-1:0]   length_q,  length_d;
  logic [TW-1:0]   timer_q,   timer_d;
  logic [3:0]      keycode_q, keycode_d;
  logic            note_en_q, note_en_d;

  // Sequence buffer. Deliberately not reset: with length cleared nothing
  // stale in here can ever be addressed.
  logic [3:0]      mem [DEPTH];
  logic            mem_we;
  logic [3:0]      mem_rdata;

  logic            live_key;
  logic            have_seq;
  logic            last_step;

  assign live_key  = (bus.keycode_i != 4'd0);
  assign have_seq  = (length_q != '0);
  // Last stored entry reached: the next step wraps back to index 0.
  assign last_step = ({1'b0, rd_ptr_q} == (length_q - 1'b1));

  // ---------------------------------------------------------------------------
  // Next-state logic
  //   Strobe priority is rec_edge > play_edge > key_edge; the if/else chain in
  //   each state encodes that directly, so a key press that coincides with a
  //   mode change never reaches the write path.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    length_d = length_q;
    timer_d  = timer_q;
    mem_we   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.rec_edge) begin
          state_d  = S_RECORD;
          wr_ptr_d = '0;
          length_d = '0;
        end else if (bus.play_edge && have_seq) begin
          state_d  = S_PLAY;
          rd_ptr_d = '0;
          timer_d  = '0;
        end
      end

      S_RECORD: begin
        if (bus.rec_edge) begin
          state_d = S_IDLE;
        end else if (bus.play_edge) begin
          if (have_seq) begin
            state_d  = S_PLAY;
            rd_ptr_d = '0;
            timer_d  = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else if (bus.key_edge && live_key) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          length_d = length_q + 1'b1;
          // The write that fills the buffer also ends recording.
          if (length_q == (LEN_FULL - 1'b1)) begin
            state_d = S_IDLE;
          end
        end
      end

      S_PLAY: begin
        if (bus.rec_edge) begin
          // Starting a new recording throws away the old sequence.
          state_d  = S_RECORD;
          wr_ptr_d = '0;
          length_d = '0;
        end else if (bus.play_edge) begin
          state_d = S_IDLE;
        end else begin
          // The step clock keeps running during a live override so the
          // loop stays in phase when the key is released.
          if (timer_q == TIMER_LAST) begin
            timer_d  = '0;
            rd_ptr_d = last_step ? '0 : (rd_ptr_q + 1'b1);
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output selection
  //   Driven from the *next* state and read pointer so the registered outputs
  //   line up with the state/step they describe: entering PLAY shows mem[0]
  //   on the first PLAY cycle, a step advance shows the new note together
  //   with the new step_o, and leaving PLAY is immediately live.
  // ---------------------------------------------------------------------------
  assign mem_rdata = mem[rd_ptr_d];

  always_comb begin
    keycode_d = bus.keycode_i;
    note_en_d = live_key;
    if (state_d == S_PLAY) begin
      keycode_d = live_key ? bus.keycode_i : mem_rdata;
      // Stored codes are never zero, so PLAY always sounds.
      note_en_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      length_q  <= '0;
      timer_q   <= '0;
      keycode_q <= 4'd0;
      note_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      length_q  <= length_d;
      timer_q   <= timer_d;
      keycode_q <= keycode_d;
      note_en_q <= note_en_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= bus.keycode_i;
    end
  end

  // step_o is the read pointer itself; it changes on the same edge as the
  // note it indexes.
  assign bus.keycode_o = keycode_q;
  assign bus.note_en   = note_en_q;
  assign bus.state_o   = state_q;
  assign bus.step_o    = rd_ptr_q;

endmodule
